// File: rtl/w0rm_core_regfile_mp.sv
// rtl/w0rm_core_regfile_mp.sv - multi-port register file with byte-enable writes, busy scoreboard and write-before-read bypass
module w0rm_core_regfile_mp #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGISTERS  = 16,
  parameter int NUM_READ_PORTS = 2,
  parameter int ZERO_REG       = 0,
  parameter int NUM_USER_BITS  = 64,
  localparam int AW            = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1,
  localparam int NB            = DATA_WIDTH / 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_READ_PORTS*AW-1:0]         rd_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]            rd_busy,
  input  logic                                 wr0_en,
  input  logic [AW-1:0]                        wr0_addr,
  input  logic [NB-1:0]                        wr0_be,
  input  logic [DATA_WIDTH-1:0]                wr0_data,
  input  logic                                 wr1_en,
  input  logic [AW-1:0]                        wr1_addr,
  input  logic [NB-1:0]                        wr1_be,
  input  logic [DATA_WIDTH-1:0]                wr1_data,
  input  logic                                 rsv_en,
  input  logic [AW-1:0]                        rsv_addr,
  output logic [NUM_REGISTERS-1:0]             busy_vec,
  input  logic [NUM_USER_BITS-1:0]             user_data_in,
  output logic [NUM_USER_BITS-1:0]             user_data_out
);

  logic [DATA_WIDTH-1:0]    mem      [NUM_REGISTERS];
  logic [DATA_WIDTH-1:0]    mem_nxt  [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] busy_nxt;

  // Next-state of every register: wr0 bytes, then wr1 bytes override, reservation beats write-clear
  always_comb begin
    busy_nxt = busy_vec;
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      mem_nxt[r] = mem[r];
      if (wr0_en && (wr0_addr == AW'(r))) begin
        for (int b = 0; b < NB; b++) begin
          if (wr0_be[b]) mem_nxt[r][b*8 +: 8] = wr0_data[b*8 +: 8];
        end
        busy_nxt[r] = 1'b0;
      end
      if (wr1_en && (wr1_addr == AW'(r))) begin
        for (int b = 0; b < NB; b++) begin
          if (wr1_be[b]) mem_nxt[r][b*8 +: 8] = wr1_data[b*8 +: 8];
        end
        busy_nxt[r] = 1'b0;
      end
      if (rsv_en && (rsv_addr == AW'(r))) busy_nxt[r] = 1'b1;
      if ((ZERO_REG != 0) && (r == 0)) begin
        mem_nxt[r]  = '0;
        busy_nxt[r] = 1'b0;
      end
    end
  end

  // Register array and busy scoreboard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGISTERS; r++) mem[r] <= '0;
      busy_vec <= '0;
    end else begin
      for (int r = 0; r < NUM_REGISTERS; r++) mem[r] <= mem_nxt[r];
      busy_vec <= busy_nxt;
    end
  end

  // Read ports sample the post-write view so same-cycle writes are bypassed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int k = 0; k < NUM_READ_PORTS; k++) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= mem_nxt[rd_addr[k*AW +: AW]];
        rd_busy[k]                          <= busy_nxt[rd_addr[k*AW +: AW]];
      end
    end
  end

  // Side-band passes through with one cycle of delay
  always_ff @(posedge clk or posedge reset) begin
    if (reset) user_data_out <= '0;
    else       user_data_out <= user_data_in;
  end

endmodule

// File: doc/w0rm_core_regfile_mp.md
W0RM_CORE_REGFILE_MP -- requirements
Module: w0rm_core_regfile_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits; multiple of 8.
REQ-002 SHALL have parameter NUM_REGISTERS, default 16, register count; power of two, at least 2.
REQ-003 SHALL have parameter NUM_READ_PORTS, default 2, independent read ports; 1 to 4.
REQ-004 SHALL have parameter ZERO_REG, default 0; 1 makes register 0 read as zero and ignore writes and reservations.
REQ-005 SHALL have parameter NUM_USER_BITS, default 64, width of the user side-band.
REQ-006 SHALL have clk  input  1  sole clock; all state on its rising edge.
REQ-007 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have rd_addr  input  NUM_READ_PORTS*AW  packed read addresses; port k at bits [k*AW +: AW], AW=log2(NUM_REGISTERS).
REQ-009 SHALL have rd_data  output  NUM_READ_PORTS*DATA_WIDTH  packed registered read data.
REQ-010 SHALL have rd_busy  output  NUM_READ_PORTS  registered busy flag of the register each port read.
REQ-011 SHALL have wr0_en/wr1_en  input  1 each  write-port enables.
REQ-012 SHALL have wr0_addr/wr1_addr  input  AW each  write addresses.
REQ-013 SHALL have wr0_be/wr1_be  input  DATA_WIDTH/8 each  byte enables.
REQ-014 SHALL have wr0_data/wr1_data  input  DATA_WIDTH each  write data.
REQ-015 SHALL have rsv_en  input  1, and rsv_addr  input  AW; marks a register busy (pending producer).
REQ-016 SHALL have busy_vec  output  NUM_REGISTERS  current busy bit per register.
REQ-017 SHALL have user_data_in  input  NUM_USER_BITS, and user_data_out  output  NUM_USER_BITS  side-band delayed one cycle.

Function
REQ-018 Write SHALL update only bytes whose be bit is 1; a write with be all-zero SHALL change no data but still clear busy.
REQ-019 When wr0 and wr1 target the same register in one cycle, each byte SHALL take wr1 data if wr1_be set, else wr0 data if wr0_be set, else old value.
REQ-020 Read latency SHALL be exactly one cycle: rd_data port k after edge N = register contents at rd_addr k sampled at edge N, with that cycle's writes merged per byte (write-before-read bypass, merge per REQ-019).
REQ-021 rd_busy port k SHALL equal the busy bit of the addressed register as updated at that same edge (REQ-022/023 applied).
REQ-022 An enabled write SHALL clear the busy bit of its target register.
REQ-023 rsv_en SHALL set the busy bit of rsv_addr; reservation and write to the same register in the same cycle SHALL leave it busy (reservation wins).
REQ-024 Reads of a busy register SHALL still return current stored/bypassed data; busy is advisory only.
REQ-025 With ZERO_REG=1, register 0 SHALL always read 0, busy bit 0, and writes/reservations to it SHALL have no effect, including bypass.
REQ-026 Out-of-range addresses cannot occur (power-of-two depth); all ports SHALL be fully independent, any combination legal every cycle.
REQ-027 user_data_out SHALL equal user_data_in registered at each rising edge.

Reset
REQ-028 reset asserted SHALL immediately clear all registers, busy_vec, rd_data, rd_busy and user_data_out to 0, without waiting for clk.
REQ-029 While reset is high all writes and reservations SHALL be ignored; first operations SHALL take effect at the first rising edge after deassertion.
REQ-030 Reset mid-operation SHALL discard pending bypass/reservation state; nothing is retained.

Verification
REQ-031 Reset, then read all registers on both ports -> rd_data 0, rd_busy 0, busy_vec 0.
REQ-032 wr0 addr 3 data 0xAABBCCDD be 0xF, same cycle rd_addr port0=3 -> next cycle rd_data port0 0xAABBCCDD; prior value 0 never observed.
REQ-033 Reg 5=0x11223344; same cycle wr0 addr5 be 0x3 data 0x0000_5566, wr1 addr5 be 0x1 data 0x0000_0077 -> reg5 = 0x11225577.
REQ-034 rsv addr 7 -> busy_vec[7]=1 next cycle; later wr1 addr7 with rsv addr7 same cycle -> busy stays 1; following write only -> busy 0.
REQ-035 ZERO_REG=1: wr0 addr0 data 0xFFFFFFFF, rsv addr0 -> reads of reg0 return 0, busy_vec[0]=0.
REQ-036 Assert reset asynchronously between edges with busy bits and data set -> outputs and busy_vec 0 before next edge; NUM_READ_PORTS=4 run repeats REQ-032 on all ports.
